// File: rtl/adc_serial_reg_receiver.sv
// Responder for the 3-wire ADC register-write bus: oversamples Sclk/Sdata/Select, deframes 32-bit writes.
// Optional ADC_SHADOW_REGS_EN adds a 16x16 shadow array with registered readback on RdData.
module adc_serial_reg_receiver #(
   parameter logic [11:0] HEADER      = 12'h001,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        InSclk,
   input  logic        InSdata,
   input  logic        InSelect,
   output logic        RegValid,
   output logic [3:0]  RegAddr,
   output logic [15:0] RegData,
   output logic        FrameError,
   output logic [1:0]  ErrCode,
   output logic        Busy,
   output logic [15:0] FrameCount,
   input  logic [3:0]  RdAddr,
   output logic [15:0] RdData
);

   localparam int unsigned FRAME_BITS = 32;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned TO_W       = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned SYNC_W     = 3;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ERR_SHORT  = 2'd1;
   localparam logic [1:0] ERR_LONG   = 2'd2;
   localparam logic [1:0] ERR_HEADER = 2'd3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SHIFT      = 2'd1,
      WAIT_DESEL = 2'd2,
      REPORT     = 2'd3
   } state_t;

   // [0],[1] = synchronizer, [2] = delay reg; preset high so an idle bus shows no edges
   logic [SYNC_W-1:0] sclk_p;
   logic [SYNC_W-1:0] sdata_p;
   logic [SYNC_W-1:0] sel_p;

   logic sclk_rise;
   logic sel_rise;
   logic sel_fall;

   state_t                  state;
   logic [FRAME_BITS-1:0]   shift_reg;
   logic [CNT_W-1:0]        bit_cnt;
   logic [TO_W-1:0]         to_cnt;
   logic                    fall_pend;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sclk_p  <= '1;
         sdata_p <= '1;
         sel_p   <= '1;
      end else begin
         sclk_p  <= {sclk_p[SYNC_W-2:0], InSclk};
         sdata_p <= {sdata_p[SYNC_W-2:0], InSdata};
         sel_p   <= {sel_p[SYNC_W-2:0], InSelect};
      end
   end

   // Registered edge flags; sdata_p[2] lines up with sclk_rise for bit capture
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sclk_rise <= 1'b0;
         sel_rise  <= 1'b0;
         sel_fall  <= 1'b0;
      end else begin
         sclk_rise <= sclk_p[1] & ~sclk_p[2];
         sel_rise  <= sel_p[1] & ~sel_p[2];
         sel_fall  <= ~sel_p[1] & sel_p[2];
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         fall_pend  <= 1'b0;
         RegValid   <= 1'b0;
         RegAddr    <= '0;
         RegData    <= '0;
         FrameError <= 1'b0;
         ErrCode    <= '0;
         Busy       <= 1'b0;
         FrameCount <= '0;
      end else begin
         RegValid   <= 1'b0;
         FrameError <= 1'b0;
         fall_pend  <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_fall || fall_pend) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  to_cnt  <= '0;
                  Busy    <= 1'b1;
               end
            end
            SHIFT: begin
               // Deselect has priority over a coincident sclk rise: that bit is dropped
               if (sel_rise) begin
                  state <= REPORT;
                  Busy  <= 1'b0;
               end else if (sclk_rise) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], sdata_p[2]};
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  to_cnt <= '0;
               end else if (to_cnt == TO_LAST) begin
                  FrameError <= 1'b1;
                  ErrCode    <= ERR_HEADER;
                  state      <= WAIT_DESEL;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_DESEL: begin
               if (sel_rise) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
            end
            REPORT: begin
               state     <= IDLE;
               fall_pend <= sel_fall;
               if (bit_cnt < CNT_FULL) begin
                  FrameError <= 1'b1;
                  ErrCode    <= ERR_SHORT;
               end else if (bit_cnt > CNT_FULL) begin
                  FrameError <= 1'b1;
                  ErrCode    <= ERR_LONG;
               end else if (shift_reg[31:20] != HEADER) begin
                  FrameError <= 1'b1;
                  ErrCode    <= ERR_HEADER;
               end else begin
                  RegValid   <= 1'b1;
                  RegAddr    <= shift_reg[19:16];
                  RegData    <= shift_reg[15:0];
                  FrameCount <= FrameCount + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADC_SHADOW_REGS_EN
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] shadow [DEPTH];

   // Shadow copy of every accepted write, read back one cycle after RdAddr
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            shadow[i] <= '0;
         end
         RdData <= '0;
      end else begin
         if (RegValid) begin
            shadow[RegAddr] <= RegData;
         end
         RdData <= shadow[RdAddr];
      end
   end
`else
   logic unused_rd_addr;

   assign unused_rd_addr = ^RdAddr;
   assign RdData         = DATA_W'(0);
`endif

endmodule

// File: tb/tb_adc_serial_reg_receiver.sv
// Scoreboard bench for adc_serial_reg_receiver: directed frames, monitor pops expected reports on each pulse.
module tb_adc_serial_reg_receiver;

   logic        Clock;
   logic        Reset_n;
   logic        InSclk;
   logic        InSdata;
   logic        InSelect;
   logic        RegValid;
   logic [3:0]  RegAddr;
   logic [15:0] RegData;
   logic        FrameError;
   logic [1:0]  ErrCode;
   logic        Busy;
   logic [15:0] FrameCount;
   logic [3:0]  RdAddr;
   logic [15:0] RdData;

   adc_serial_reg_receiver dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .InSclk     (InSclk),
      .InSdata    (InSdata),
      .InSelect   (InSelect),
      .RegValid   (RegValid),
      .RegAddr    (RegAddr),
      .RegData    (RegData),
      .FrameError (FrameError),
      .ErrCode    (ErrCode),
      .Busy       (Busy),
      .FrameCount (FrameCount),
      .RdAddr     (RdAddr),
      .RdData     (RdData)
   );

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [15:0] cnt;
      int          lo;
      int          hi;
   } exp_t;

   exp_t        sbq[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   logic [3:0]  m_addr = 4'h0;
   logic [15:0] m_data = 16'h0;
   logic [15:0] m_cnt  = 16'h0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest pending expectation
   always @(negedge Clock) begin
      if (Reset_n && (RegValid || FrameError)) begin
         tests++;
         if (RegValid && FrameError) begin
            fails++;
            $display("FAIL both_pulses: RegValid and FrameError high together at cycle %0d", cyc);
         end
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: valid=%0b error=%0b code=%0d at cycle %0d, nothing expected",
                     RegValid, FrameError, ErrCode, cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("pulse_kind", {31'd0, FrameError}, {31'd0, e.is_err});
            if (e.is_err) chk("err_code", {30'd0, ErrCode}, {30'd0, e.code});
            chk("reg_addr", {28'd0, RegAddr}, {28'd0, e.addr});
            chk("reg_data", {16'd0, RegData}, {16'd0, e.data});
            chk("frame_count", {16'd0, FrameCount}, {16'd0, e.cnt});
            tests++;
            if (cyc < e.lo || cyc > e.hi) begin
               fails++;
               $display("FAIL latency: pulse at cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
            end
         end
      end
   end

   task automatic clocks(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic drain();
      int t = 0;
      while (sbq.size() != 0 && t < 3000) begin
         clocks(1);
         t++;
      end
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d expected reports never seen", sbq.size());
         sbq.delete();
      end
   endtask

   // Select low, then n bits MSB first at sclk = Clock/8
   task automatic shift_bits(input logic [63:0] bits, input int n);
      InSelect = 1'b0;
      clocks(4);
      for (int i = n - 1; i >= 0; i--) begin
         InSdata = bits[i];
         clocks(4);
         InSclk = 1'b1;
         clocks(4);
         InSclk = 1'b0;
         if (i == n - 9) chk("busy_mid_frame", {31'd0, Busy}, 32'd1);
      end
      clocks(4);
   endtask

   task automatic finish_frame(input exp_t e_in);
      exp_t e;
      e    = e_in;
      e.lo = cyc + 5;
      e.hi = cyc + 5;
      sbq.push_back(e);
      InSelect = 1'b1;
      clocks(12);
      chk("busy_after_frame", {31'd0, Busy}, 32'd0);
   endtask

   task automatic send_good(input logic [31:0] frame);
      exp_t e;
      m_addr   = frame[19:16];
      m_data   = frame[15:0];
      m_cnt    = m_cnt + 16'd1;
      e.is_err = 1'b0;
      e.code   = 2'd0;
      e.addr   = m_addr;
      e.data   = m_data;
      e.cnt    = m_cnt;
      shift_bits({32'd0, frame}, 32);
      finish_frame(e);
      drain();
   endtask

   task automatic send_bad(input logic [63:0] bits, input int n, input logic [1:0] code);
      exp_t e;
      e.is_err = 1'b1;
      e.code   = code;
      e.addr   = m_addr;
      e.data   = m_data;
      e.cnt    = m_cnt;
      shift_bits(bits, n);
      finish_frame(e);
      drain();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, RegValid}, 32'd0);
      chk({tag, "_error"}, {31'd0, FrameError}, 32'd0);
      chk({tag, "_addr"}, {28'd0, RegAddr}, 32'd0);
      chk({tag, "_data"}, {16'd0, RegData}, 32'd0);
      chk({tag, "_code"}, {30'd0, ErrCode}, 32'd0);
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
      chk({tag, "_count"}, {16'd0, FrameCount}, 32'd0);
      chk({tag, "_rddata"}, {16'd0, RdData}, 32'd0);
   endtask

   initial begin
      exp_t e;
      Reset_n  = 1'b0;
      InSclk   = 1'b0;
      InSdata  = 1'b0;
      InSelect = 1'b1;
      RdAddr   = 4'h0;
      clocks(3);
      check_idle_outputs("reset");
      Reset_n = 1'b1;
      clocks(5);

      send_good(32'h0011_A5C3);
      send_bad(64'h0000_0000_0011_A5C3, 31, 2'd1);
      send_bad(64'h0000_0001_0011_A5C3, 33, 2'd2);
      send_bad(64'h0000_0000_0022_1234, 32, 2'd3);
      send_good(32'h001F_FFFF);
      send_good(32'h0010_0000);

      // Select held low with no sclk: one timeout error, nothing on deselect
      e.is_err = 1'b1;
      e.code   = 2'd3;
      e.addr   = m_addr;
      e.data   = m_data;
      e.cnt    = m_cnt;
      e.lo     = cyc + 1 + 1020;
      e.hi     = cyc + 1 + 1032;
      sbq.push_back(e);
      InSelect = 1'b0;
      clocks(1100);
      chk("busy_after_timeout", {31'd0, Busy}, 32'd1);
      InSelect = 1'b1;
      clocks(40);
      chk("busy_after_desel", {31'd0, Busy}, 32'd0);
      drain();

      send_good(32'h0015_5AA5);

      // Reset in the middle of a frame drops it and clears the counter
      shift_bits(64'h0000_0000_0011_ABCD, 16);
      Reset_n  = 1'b0;
      InSelect = 1'b1;
      clocks(3);
      check_idle_outputs("midreset");
      Reset_n = 1'b1;
      m_addr  = 4'h0;
      m_data  = 16'h0;
      m_cnt   = 16'h0;
      clocks(5);
      send_good(32'h0017_00FF);

      send_good(32'h0013_1234);
      send_good(32'h0017_BEEF);
`ifdef ADC_SHADOW_REGS_EN
      RdAddr = 4'h3;
      clocks(2);
      chk("shadow_addr3", {16'd0, RdData}, 32'h0000_1234);
      RdAddr = 4'h7;
      clocks(2);
      chk("shadow_addr7", {16'd0, RdData}, 32'h0000_BEEF);
      RdAddr = 4'h5;
      clocks(2);
      chk("shadow_addr5", {16'd0, RdData}, 32'h0000_0000);
`else
      RdAddr = 4'h3;
      clocks(2);
      chk("rddata_tied", {16'd0, RdData}, 32'h0000_0000);
`endif

      clocks(50);
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
